// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bus bundle shared by the requesters and the SDRAM controller side.
// The master modport drives commands and the slave modport answers them.
interface sdram_port_arbiter_if #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
);
  logic [ADDRESSWIDTH-1:0] address;
  logic                    read;
  logic                    write;
  logic [DATAWIDTH-1:0]    writedata;
  logic [DATAWIDTH/8-1:0]  byteenable;
  logic                    waitrequest;
  logic [DATAWIDTH-1:0]    readdata;
  logic                    readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter for the SDRAM controller: port 0 has fixed priority,
// port 1 is protected by a starvation guard, and stuck reads are completed by a timeout.
module sdram_port_arbiter #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32,
  parameter int MAX_WAIT     = 4,
  parameter int RD_TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  s0,
  sdram_port_arbiter_if.slave  s1,
  sdram_port_arbiter_if.master m,
  output logic [1:0]           grant,
  output logic                 timeout_flag
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(RD_TIMEOUT);
  localparam logic [DATAWIDTH-1:0] TIMEOUT_DATA = DATAWIDTH'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  nxt_state_s;
  logic [1:0]              grant_r;
  logic [1:0]              pick_s;
  logic [SW-1:0]           starve_cnt_r;
  logic [TW-1:0]           timer_r;
  logic                    timeout_flag_r;
  logic                    req0_s;
  logic                    req1_s;
  logic                    sel_read_s;
  logic                    sel_write_s;
  logic [ADDRESSWIDTH-1:0] sel_address_s;
  logic [DATAWIDTH-1:0]    sel_writedata_s;
  logic [DATAWIDTH/8-1:0]  sel_byteenable_s;
  logic                    rd_done_s;
  logic                    rd_timeout_s;
  logic [DATAWIDTH-1:0]    rd_data_s;

  // Requests and the granted port's command, muxed on the registered grant
  always_comb begin
    req0_s = s0.read | s0.write;
    req1_s = s1.read | s1.write;
    if (grant_r[1]) begin
      sel_read_s       = s1.read;
      sel_write_s      = s1.write;
      sel_address_s    = s1.address;
      sel_writedata_s  = s1.writedata;
      sel_byteenable_s = s1.byteenable;
    end else begin
      sel_read_s       = s0.read;
      sel_write_s      = s0.write;
      sel_address_s    = s0.address;
      sel_writedata_s  = s0.writedata;
      sel_byteenable_s = s0.byteenable;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Arbitration choice, next state and read-completion events
  always_comb begin
    nxt_state_s  = state_r;
    pick_s       = 2'b00;
    rd_done_s    = 1'b0;
    rd_timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_s && req1_s) begin
          if (starve_cnt_r == STARVE_MAX) begin
            pick_s = 2'b10;
          end else begin
            pick_s = 2'b01;
          end
        end else if (req1_s) begin
          pick_s = 2'b10;
        end else if (req0_s) begin
          pick_s = 2'b01;
        end else begin
          pick_s = 2'b00;
        end
        if (req0_s || req1_s) begin
          nxt_state_s = ISSUE;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!m.waitrequest) begin
          // a read+write request is a read, so it must wait for data
          if (sel_read_s) begin
            nxt_state_s = RD_WAIT;
          end else begin
            nxt_state_s = IDLE;
          end
        end else begin
          nxt_state_s = ISSUE;
        end
      end
      RD_WAIT: begin
        if (m.readdatavalid) begin
          rd_done_s   = 1'b1;
          nxt_state_s = IDLE;
        end else if (timer_r == TIMER_MAX) begin
          rd_done_s    = 1'b1;
          rd_timeout_s = 1'b1;
          nxt_state_s  = IDLE;
        end else begin
          nxt_state_s = RD_WAIT;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // Bus outputs: controller command in ISSUE, read return in RD_WAIT
  always_comb begin
    m.address        = '0;
    m.read           = 1'b0;
    m.write          = 1'b0;
    m.writedata      = '0;
    m.byteenable     = '0;
    s0.waitrequest   = 1'b1;
    s1.waitrequest   = 1'b1;
    s0.readdata      = '0;
    s1.readdata      = '0;
    s0.readdatavalid = 1'b0;
    s1.readdatavalid = 1'b0;
    if (rd_timeout_s && !m.readdatavalid) begin
      rd_data_s = TIMEOUT_DATA;
    end else begin
      rd_data_s = m.readdata;
    end
    case (state_r)
      ISSUE: begin
        m.address    = sel_address_s;
        m.writedata  = sel_writedata_s;
        m.byteenable = sel_byteenable_s;
        m.read       = sel_read_s;
        m.write      = sel_write_s & ~sel_read_s;
        if (grant_r[1]) begin
          s1.waitrequest = m.waitrequest;
        end else begin
          s0.waitrequest = m.waitrequest;
        end
      end
      RD_WAIT: begin
        if (grant_r[1]) begin
          s1.readdata      = rd_data_s;
          s1.readdatavalid = rd_done_s;
        end else begin
          s0.readdata      = rd_data_s;
          s0.readdatavalid = rd_done_s;
        end
      end
      default: begin
        m.read = 1'b0;
      end
    endcase
  end

  // Grant owner, starvation count, read timer and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_r        <= 2'b00;
      starve_cnt_r   <= '0;
      timer_r        <= '0;
      timeout_flag_r <= 1'b0;
    end else begin
      if (state_r == RD_WAIT && nxt_state_s == RD_WAIT) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= '0;
      end

      if (nxt_state_s == IDLE) begin
        grant_r <= 2'b00;
      end else if (state_r == IDLE) begin
        grant_r <= pick_s;
      end else begin
        grant_r <= grant_r;
      end

      // only port 0 wins over a waiting port 1 count toward starvation
      if (state_r == IDLE && pick_s == 2'b10) begin
        starve_cnt_r <= '0;
      end else if (state_r == IDLE && pick_s == 2'b01 && req1_s &&
                   starve_cnt_r != STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end

      if (rd_timeout_s) begin
        timeout_flag_r <= 1'b1;
      end else begin
        timeout_flag_r <= timeout_flag_r;
      end
    end
  end

  assign grant        = grant_r;
  assign timeout_flag = timeout_flag_r;

endmodule
